// File: rtl/fft_frame_capture.sv
// Receive-side frame buffer for the FFT output stream. It captures 256-sample framed
// blocks into a two-bank ping-pong RAM and replays them over a valid/ready port.
// The optional per-bank checksum is enabled by defining FFT_CAP_CHECKSUM_EN.
module fft_frame_capture #(
  parameter int DW   = 20,
  parameter int NPTS = 256,
  parameter int AW   = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] in_real,
  input  logic [DW-1:0] in_imag,
  input  logic          in_start,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [DW-1:0] rd_real,
  output logic [DW-1:0] rd_imag,
  output logic [AW-1:0] rd_idx,
  output logic          rd_last,
  output logic          frame_err,
  output logic [7:0]    drop_cnt,
  output logic [15:0]   checksum
);

  typedef enum logic [1:0] {EMPTY, FILLING, FULL, READING} bank_state_t;
  typedef enum logic [1:0] {W_IDLE, W_FILL, W_SKIP} wr_state_t;
  typedef enum logic {R_IDLE, R_SEND} rd_state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(NPTS - 1);

  logic [DW-1:0] mem_real [0:2*NPTS-1];
  logic [DW-1:0] mem_imag [0:2*NPTS-1];

  wr_state_t   wr_state, wr_state_nxt;
  rd_state_t   rd_state, rd_state_nxt;
  bank_state_t bank_st  [2];
  bank_state_t bank_nxt [2];

  logic          wr_bank, wr_bank_nxt;
  logic [AW-1:0] wr_idx, wr_idx_nxt;
  logic          we, we_bank;
  logic [AW-1:0] we_idx;
  logic          do_alloc, alloc_ok, mark_full, err_nxt, drop_inc;
  logic          any_empty, alloc_bank;
  logic          oldest, rd_bank, rd_pick, rd_take, has_full;
  logic [AW-1:0] fetch_idx;
  logic          fetch_done, load, last_hs;

  assign any_empty  = (bank_st[0] == EMPTY) || (bank_st[1] == EMPTY);
  assign alloc_bank = (bank_st[0] == EMPTY) ? 1'b0 : 1'b1;

  // Write side: a new frame (or a restart) claims the lowest EMPTY bank, else it is skipped.
  always_comb begin
    wr_state_nxt = wr_state;
    wr_bank_nxt  = wr_bank;
    wr_idx_nxt   = wr_idx;
    we           = 1'b0;
    we_bank      = wr_bank;
    we_idx       = wr_idx;
    do_alloc     = 1'b0;
    alloc_ok     = 1'b0;
    mark_full    = 1'b0;
    err_nxt      = 1'b0;
    drop_inc     = 1'b0;
    case (wr_state)
      W_IDLE: do_alloc = in_start;
      W_FILL: begin
        we = 1'b1;
        if (in_start && wr_idx != '0) begin
          err_nxt    = 1'b1;
          we_idx     = '0;
          wr_idx_nxt = AW'(1);
        end else if (wr_idx == LAST_IDX) begin
          mark_full    = 1'b1;
          wr_state_nxt = W_IDLE;
          wr_idx_nxt   = '0;
        end else begin
          wr_idx_nxt = wr_idx + 1'b1;
        end
      end
      W_SKIP: begin
        if (in_start && wr_idx != '0) begin
          err_nxt  = 1'b1;
          do_alloc = 1'b1;
        end else if (wr_idx == LAST_IDX) begin
          wr_state_nxt = W_IDLE;
          wr_idx_nxt   = '0;
        end else begin
          wr_idx_nxt = wr_idx + 1'b1;
        end
      end
      default: wr_state_nxt = W_IDLE;
    endcase
    if (do_alloc) begin
      wr_idx_nxt = AW'(1);
      if (any_empty) begin
        alloc_ok     = 1'b1;
        we           = 1'b1;
        we_bank      = alloc_bank;
        we_idx       = '0;
        wr_bank_nxt  = alloc_bank;
        wr_state_nxt = W_FILL;
      end else begin
        drop_inc     = 1'b1;
        wr_state_nxt = W_SKIP;
      end
    end
  end

  // Handshake: a sample transfers on a rising edge with rd_valid && rd_ready; while
  // rd_valid is high and rd_ready low, every rd_* output is held unchanged.
  assign has_full = (bank_st[0] == FULL) || (bank_st[1] == FULL);
  assign rd_pick  = (bank_st[0] == FULL && bank_st[1] == FULL) ? oldest : (bank_st[1] == FULL);
  assign last_hs  = rd_valid && rd_ready && rd_last;
  assign load     = (rd_state == R_SEND) && !fetch_done && (!rd_valid || rd_ready);

  always_comb begin
    rd_state_nxt = rd_state;
    rd_take      = 1'b0;
    case (rd_state)
      R_IDLE: if (has_full) begin
        rd_take      = 1'b1;
        rd_state_nxt = R_SEND;
      end
      R_SEND: if (last_hs) rd_state_nxt = R_IDLE;
      default: rd_state_nxt = R_IDLE;
    endcase
  end

  // Writer and reader only ever touch different banks, so both updates can apply together.
  always_comb begin
    bank_nxt[0] = bank_st[0];
    bank_nxt[1] = bank_st[1];
    if (alloc_ok)  bank_nxt[alloc_bank] = FILLING;
    if (mark_full) bank_nxt[wr_bank]    = FULL;
    if (rd_take)   bank_nxt[rd_pick]    = READING;
    if (last_hs)   bank_nxt[rd_bank]    = EMPTY;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_state   <= W_IDLE;
      rd_state   <= R_IDLE;
      bank_st[0] <= EMPTY;
      bank_st[1] <= EMPTY;
      wr_bank    <= 1'b0;
      wr_idx     <= '0;
      rd_bank    <= 1'b0;
      oldest     <= 1'b0;
      frame_err  <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      wr_state   <= wr_state_nxt;
      rd_state   <= rd_state_nxt;
      bank_st[0] <= bank_nxt[0];
      bank_st[1] <= bank_nxt[1];
      wr_bank    <= wr_bank_nxt;
      wr_idx     <= wr_idx_nxt;
      frame_err  <= err_nxt;
      if (rd_take) rd_bank <= rd_pick;
      if (mark_full && bank_st[~wr_bank] != FULL) oldest <= wr_bank;
      if (drop_inc && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem_real[{we_bank, we_idx}] <= in_real;
      mem_imag[{we_bank, we_idx}] <= in_imag;
    end
  end

  // The output register doubles as the RAM read register (one cycle read latency).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_valid   <= 1'b0;
      rd_real    <= '0;
      rd_imag    <= '0;
      rd_idx     <= '0;
      rd_last    <= 1'b0;
      fetch_idx  <= '0;
      fetch_done <= 1'b0;
    end else if (rd_take) begin
      fetch_idx  <= '0;
      fetch_done <= 1'b0;
    end else if (load) begin
      rd_valid <= 1'b1;
      rd_real  <= mem_real[{rd_bank, fetch_idx}];
      rd_imag  <= mem_imag[{rd_bank, fetch_idx}];
      rd_idx   <= fetch_idx;
      rd_last  <= (fetch_idx == LAST_IDX);
      if (fetch_idx == LAST_IDX) fetch_done <= 1'b1;
      else                       fetch_idx  <= fetch_idx + 1'b1;
    end else if (rd_valid && rd_ready) begin
      rd_valid <= 1'b0;
    end
  end

`ifdef FFT_CAP_CHECKSUM_EN
  logic [15:0] sum_q [2];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_q[0] <= '0;
      sum_q[1] <= '0;
    end else if (we) begin
      sum_q[we_bank] <= ((we_idx == '0) ? 16'd0 : sum_q[we_bank]) + in_real[15:0] + in_imag[15:0];
    end
  end

  assign checksum = (rd_valid && rd_last) ? sum_q[rd_bank] : 16'd0;
`else
  assign checksum = 16'd0;
`endif

endmodule

// File: tb/tb_fft_frame_capture.sv
// Directed bench for fft_frame_capture: drives framed FFT blocks and checks the replayed
// stream against a queue of expected samples.
module tb_fft_frame_capture;
  localparam int DW = 20;
  localparam int NPTS = 256;
  localparam int AW = 8;
  localparam int W = 64;
`ifdef FFT_CAP_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] in_real, in_imag;
  logic          in_start;
  logic          rd_valid, rd_ready;
  logic [DW-1:0] rd_real, rd_imag;
  logic [AW-1:0] rd_idx;
  logic          rd_last, frame_err;
  logic [7:0]    drop_cnt;
  logic [15:0]   checksum;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int err_pulses = 0;
  int delivered = 0;
  bit rand_ready = 1'b0;
  logic prev_stall = 1'b0;
  logic [48:0] snap = '0;
  logic [15:0] last_ck = '0;

  // clock / reset
  always #5 clk = ~clk;

  fft_frame_capture #(.DW(DW), .NPTS(NPTS), .AW(AW)) dut (
    .clk(clk), .reset(reset), .in_real(in_real), .in_imag(in_imag), .in_start(in_start),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_real(rd_real), .rd_imag(rd_imag),
    .rd_idx(rd_idx), .rd_last(rd_last), .frame_err(frame_err), .drop_cnt(drop_cnt),
    .checksum(checksum)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) rd_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic drive(input logic s, input logic [DW-1:0] r, input logic [DW-1:0] i);
    in_start = s;
    in_real  = r;
    in_imag  = i;
    tick();
  endtask

  task automatic idle(input int n);
    in_start = 1'b0;
    repeat (n) tick();
  endtask

  // pat 0: real=k, imag=-k; pat 1: random; pat 2: real=1, imag=2
  task automatic send_frame(input int pat, input bit keep);
    logic [DW-1:0] r, i;
    logic [15:0] sum;
    logic [15:0] ck;
    sum = '0;
    for (int k = 0; k < NPTS; k++) begin
      case (pat)
        0: begin r = DW'(k); i = -DW'(k); end
        1: begin r = DW'($urandom); i = DW'($urandom); end
        default: begin r = DW'(1); i = DW'(2); end
      endcase
      sum = sum + r[15:0] + i[15:0];
      ck = (k == NPTS - 1 && CK_EN) ? sum : 16'd0;
      if (keep) exp_q.push_back({AW'(k), r, i, ck});
      drive(k == 0, r, i);
    end
    in_start = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int c;
    c = 0;
    while ((exp_q.size() != 0 || rd_valid) && c < budget) begin
      tick();
      c++;
    end
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // scoreboard monitor, sampled on the falling edge
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (reset !== 1'b1) begin
      prev_stall = 1'b0;
    end else begin
      if (frame_err) err_pulses++;
      if (prev_stall) check("stall_hold", {rd_valid, rd_idx, rd_real, rd_imag}, snap);
      if (rd_valid && rd_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $error("FAIL unexpected_output observed idx=%0d expected none", rd_idx);
        end else begin
          e = exp_q.pop_front();
          check("rd_sample", {rd_idx, rd_real, rd_imag, checksum}, e);
          check("rd_last", 64'(rd_last), 64'(e[63:56] == 8'(NPTS - 1)));
          if (e[63:56] == 8'(NPTS - 1)) last_ck = checksum;
          delivered++;
        end
      end
      prev_stall = rd_valid && !rd_ready;
      snap = {rd_valid, rd_idx, rd_real, rd_imag};
    end
  end

  initial begin
    reset = 1'b0;
    in_start = 1'b0;
    in_real = '0;
    in_imag = '0;
    rd_ready = 1'b0;
    repeat (3) tick();
    check("rst_outputs", {rd_valid, rd_last, frame_err, rd_idx, drop_cnt, checksum},
          64'd0);
    check("rst_data", {rd_real, rd_imag}, 64'd0);
    reset = 1'b1;
    idle(2);

    // one frame, ramp data, consumer always ready
    rd_ready = 1'b1;
    send_frame(0, 1'b1);
    check("latency_e0", 64'(rd_valid), 64'd0);
    tick();
    check("latency_e1", 64'(rd_valid), 64'd0);
    tick();
    check("latency_e2_valid", 64'(rd_valid), 64'd1);
    check("latency_e2_idx", 64'(rd_idx), 64'd0);
    wait_drain(2000);
    check("t1_delivered", 64'(delivered), 64'(NPTS));
    check("t1_frame_err", 64'(err_pulses), 64'd0);
    check("t1_drop_cnt", 64'(drop_cnt), 64'd0);
    idle(4);

    // three back-to-back frames with the consumer stalled: third is dropped
    rd_ready = 1'b0;
    send_frame(1, 1'b1);
    send_frame(1, 1'b1);
    send_frame(1, 1'b0);
    idle(3);
    check("t2_drop_cnt", 64'(drop_cnt), 64'd1);
    check("t2_frame_err", 64'(err_pulses), 64'd0);
    rd_ready = 1'b1;
    wait_drain(3000);
    check("t2_delivered", 64'(delivered), 64'(3 * NPTS));
    idle(4);

    // restart at index 100: partial frame discarded, restart becomes sample 0
    for (int k = 0; k < 100; k++) drive(k == 0, DW'(32'hABC00 + k), DW'(k));
    send_frame(0, 1'b1);
    wait_drain(2000);
    check("t3_frame_err_once", 64'(err_pulses), 64'd1);
    check("t3_delivered", 64'(delivered), 64'(4 * NPTS));
    idle(4);

    // random back-pressure across two frames
    rand_ready = 1'b1;
    send_frame(1, 1'b1);
    send_frame(1, 1'b1);
    wait_drain(4000);
    rand_ready = 1'b0;
    rd_ready = 1'b1;
    check("t4_delivered", 64'(delivered), 64'(6 * NPTS));
    check("t4_drop_cnt", 64'(drop_cnt), 64'd1);
    idle(4);

    // reset mid-frame with one bank READING and one FULL
    rd_ready = 1'b0;
    send_frame(1, 1'b0);
    send_frame(1, 1'b0);
    for (int k = 0; k < 37; k++) drive(k == 0, DW'($urandom), DW'($urandom));
    check("t5_pre_valid", 64'(rd_valid), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    check("t5_async_ctrl", {rd_valid, rd_last, frame_err, rd_idx, drop_cnt, checksum},
          64'd0);
    check("t5_async_data", {rd_real, rd_imag}, 64'd0);
    in_start = 1'b0;
    exp_q.delete();
    idle(3);
    reset = 1'b1;
    idle(3);
    check("t5_post_idle", 64'(rd_valid), 64'd0);

    // constant frame after reset, checksum at the last sample
    rd_ready = 1'b1;
    send_frame(2, 1'b1);
    wait_drain(2000);
    check("t6_delivered", 64'(delivered), 64'(7 * NPTS));
    check("t6_checksum", 64'(last_ck), CK_EN ? 64'h0300 : 64'h0000);
    check("t6_drop_cnt", 64'(drop_cnt), 64'd0);
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fft_frame_capture.md
Name: fft_frame_capture

Overview:
- Receive end of the FFT output stream: accepts the 256-sample start-framed block (first sample flagged by start, 255 contiguous samples follow, one per clock, no stall).
- Stores each block in a two-bank ping-pong buffer.
- Replays blocks to a downstream consumer over a valid/ready handshake.
- Sits between fft and any slower post-processing (magnitude, host readout) so FFT output never back-pressures.

Parameters:
- DW, 20, sample width of real and imag (two's complement)
- NPTS, 256, samples per frame
- AW, 8, index width (clog2 of NPTS)

Ports:
- clk  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset (asserted 0)
- in_real  in  DW  FFT output real sample
- in_imag  in  DW  FFT output imag sample
- in_start  in  1  high on sample 0 of a frame only
- rd_valid  out  1  rd_* outputs hold a sample
- rd_ready  in  1  consumer accepts sample when rd_valid&rd_ready
- rd_real  out  DW  buffered real sample
- rd_imag  out  DW  buffered imag sample
- rd_idx  out  AW  sample index within frame, 0..NPTS-1
- rd_last  out  1  high with rd_idx==NPTS-1
- frame_err  out  1  one-cycle pulse on framing error
- drop_cnt  out  8  frames dropped for lack of a free bank, saturates at 8'hFF
- checksum  out  16  see Optional Feature

Behaviour:
- Reset: all outputs 0; both banks EMPTY; write FSM W_IDLE; read FSM R_IDLE; write bank pointer 0, read bank pointer 0.
- Bank states: EMPTY, FILLING, FULL, READING.
- Write FSM, W_IDLE:
  - in_start=1 and a bank is EMPTY: store sample at index 0 of the lowest-numbered EMPTY bank, mark it FILLING, go to W_FILL.
  - in_start=1 and no bank EMPTY: increment drop_cnt (saturating) and go to W_SKIP.
  - Samples with in_start=0 are ignored.
- Write FSM, W_FILL:
  - Store one sample per clock and increment the index.
  - At index NPTS-1, mark the bank FULL and go to W_IDLE.
  - An in_start on the cycle after the last sample is accepted normally (back-to-back frames).
- Write FSM, W_SKIP: count NPTS-1 samples, then go to W_IDLE. An in_start during W_SKIP is handled as in W_FILL.
- Framing error: in_start=1 in W_FILL or W_SKIP at index!=0.
  - Pulse frame_err one cycle.
  - Discard the partial frame; the bank stays FILLING and restarts at index 0 with this sample.
  - From W_SKIP, retry bank allocation as in W_IDLE.
- Read FSM:
  - R_IDLE: when a FULL bank exists (oldest first; tie impossible), mark it READING and go to R_SEND.
  - rd_valid rises 2 cycles after that bank became FULL (1-cycle RAM read latency).
  - R_SEND: rd_* are registered and held stable while rd_valid&!rd_ready. Each handshake advances the index, with the next sample presented the following cycle (full throughput when rd_ready held high).
  - rd_last=1 exactly on index NPTS-1.
  - On the last handshake: bank becomes EMPTY next cycle, rd_valid drops, go to R_IDLE.
  - The other FULL bank starts with the same 2-cycle latency.
- Simultaneous events:
  - Bank freed in the same cycle as an in_start that finds no EMPTY bank: the frame is dropped (freeing becomes visible next cycle).
  - A frame completing in the same cycle the read side finishes the other bank: both updates apply.
- Ordering: frames are delivered in arrival order, unmodified, with no gaps inside a frame.
- Reset asserted mid-operation: all frames discarded immediately, state as at reset, no partial output after release.

Optional Feature:
- Macro: FFT_CAP_CHECKSUM_EN.
- Defined: a 16-bit running sum of in_real[15:0]+in_imag[15:0] (mod 2^16) is kept per bank. checksum presents the bank's sum when rd_last&rd_valid, else 0. A framing-error restart clears the sum.
- Undefined: no sum logic; checksum tied to 0.

Test Plan:
- One frame, samples real=i, imag=-i (i=0..255), rd_ready=1 -> rd_valid high 2 cycles after capture end; rd_idx 0..255 with matching data; rd_last only at idx 255; frame_err=0, drop_cnt=0.
- Three back-to-back frames, rd_ready=0 -> frames 1 and 2 buffered, frame 3 dropped (drop_cnt=1). Then rd_ready=1 -> frames 1 then 2 delivered intact.
- in_start re-asserted at index 100 of a frame -> frame_err pulses once; the next 256 samples from that start are delivered as a full frame with idx 0 = the restart sample.
- rd_ready toggled randomly (50%) during a frame -> rd_real/rd_imag/rd_idx stable across every stall cycle; all 256 samples delivered exactly once.
- reset pulled low at write index 37 with one bank FULL -> all outputs 0 asynchronously, rd_valid=0; the next frame after release is captured and delivered normally.
- FFT_CAP_CHECKSUM_EN defined, frame of all real=1, imag=2 -> checksum=16'h0300 at rd_last.
